// File: rtl/iloader_pkg.sv
// Shared types and constants for the instruction RAM boot loader.
package iloader_pkg;

  localparam int ILOADER_LEN_BYTES  = 2;
  localparam int ILOADER_WORD_BYTES = 4;
  localparam int ILOADER_DEPTH      = 616;
  localparam int ILOADER_ADDR_W     = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } iloader_state_e;

endpackage

// File: rtl/iloader_word_assembler.sv
// Packs a byte stream MSB-first into 32-bit words; word_valid_o marks the
// cycle in which the final byte of a word is presented.
module iloader_word_assembler
  import iloader_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clr_i,
  input  logic        byte_en_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  localparam logic [1:0] LAST_IDX = 2'(ILOADER_WORD_BYTES - 1);

  logic [23:0] shift_q;
  logic [1:0]  cnt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (clr_i) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (byte_en_i) begin
      shift_q <= {shift_q[15:0], byte_i};
      cnt_q   <= cnt_q + 2'd1;
    end
  end

  // The word completes combinationally so the top can register it on the
  // same edge that accepts the final byte.
  assign word_valid_o = byte_en_i && !clr_i && (cnt_q == LAST_IDX);
  assign word_o       = {shift_q, byte_i};

endmodule

// File: rtl/instruction_ram_loader.sv
// Boot loader: length-prefixed big-endian word stream into instruction RAM.
// Define ILOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module instruction_ram_loader
  import iloader_pkg::*;
#(
  parameter int DEPTH     = ILOADER_DEPTH,
  parameter int ADDR_W    = ILOADER_ADDR_W,
  parameter int BASE_ADDR = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] i_ram_writing_address,
  output logic [31:0]       i_ram_input,
  output logic              flag_write_i_ram,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [16:0]       LEN_LIMIT = 17'(DEPTH - BASE_ADDR);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

`ifdef ILOADER_CHECKSUM_EN
  localparam iloader_state_e LEN_END = ST_CHECK;
`else
  localparam iloader_state_e LEN_END = ST_DONE;
`endif

  iloader_state_e    state_q, state_d;
  logic [7:0]        len_hi_q;
  logic [15:0]       words_left_q;
  logic [ADDR_W-1:0] addr_next_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic              wr_q;

  logic        accept;
  logic        start_ok;
  logic        feed;
  logic        word_valid;
  logic [31:0] word;
  logic [15:0] len;

  assign byte_ready = state_q inside {ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_CHECK};
  assign busy       = state_q inside {ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_CHECK};
  assign done       = (state_q == ST_DONE);
  assign error      = (state_q == ST_ERROR);

  assign accept   = byte_valid && byte_ready && !abort;
  assign start_ok = start && !abort && (state_q inside {ST_IDLE, ST_DONE, ST_ERROR});
  // Bytes offered after the last word (pulse cycle) are not part of the image.
  assign feed     = accept && (state_q == ST_DATA) && (words_left_q != 16'd0);
  assign len      = {len_hi_q, byte_in};

  iloader_word_assembler u_asm (
    .clock        (clock),
    .reset_n      (reset_n),
    .clr_i        (abort || start_ok),
    .byte_en_i    (feed),
    .byte_i       (byte_in),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

`ifdef ILOADER_CHECKSUM_EN
  logic [7:0] csum_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      csum_q <= '0;
    end else if (start_ok) begin
      csum_q <= '0;
    end else if ((accept && (state_q inside {ST_LEN_HI, ST_LEN_LO})) || feed) begin
      csum_q <= csum_q ^ byte_in;
    end
  end
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERROR: if (start) state_d = ST_LEN_HI;
        ST_LEN_HI: if (accept) state_d = ST_LEN_LO;
        ST_LEN_LO: begin
          if (accept) begin
            if (len == 16'd0)                 state_d = LEN_END;
            else if ({1'b0, len} > LEN_LIMIT) state_d = ST_ERROR;
            else                              state_d = ST_DATA;
          end
        end
`ifdef ILOADER_CHECKSUM_EN
        ST_DATA:  if (word_valid && (words_left_q == 16'd1)) state_d = ST_CHECK;
        ST_CHECK: if (accept) state_d = (byte_in == csum_q) ? ST_DONE : ST_ERROR;
`else
        // Linger one cycle so done rises only after the final write pulse.
        ST_DATA:  if (words_left_q == 16'd0) state_d = ST_DONE;
`endif
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      len_hi_q     <= '0;
      words_left_q <= '0;
      addr_next_q  <= BASE;
      addr_q       <= '0;
      data_q       <= '0;
      wr_q         <= 1'b0;
    end else begin
      wr_q <= 1'b0;
      if (!abort) begin
        if (start_ok) begin
          addr_next_q  <= BASE;
          words_left_q <= '0;
        end
        if (accept && (state_q == ST_LEN_HI)) len_hi_q     <= byte_in;
        if (accept && (state_q == ST_LEN_LO)) words_left_q <= len;
        if (word_valid) begin
          wr_q         <= 1'b1;
          data_q       <= word;
          addr_q       <= addr_next_q;
          addr_next_q  <= addr_next_q + 1'b1;
          words_left_q <= words_left_q - 16'd1;
        end
      end
    end
  end

  assign flag_write_i_ram      = wr_q;
  assign i_ram_input           = data_q;
  assign i_ram_writing_address = addr_q;

endmodule

// File: tb/tb_instruction_ram_loader.sv
// Self-checking bench for instruction_ram_loader (default parameters).
module tb_instruction_ram_loader;

  localparam int DEPTH = 616;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic        byte_ready, flag_write_i_ram, busy, done, error;
  logic [9:0]  i_ram_writing_address;
  logic [31:0] i_ram_input;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [9:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  logic [31:0] words_q[$];
  int          done_cyc = -1;
  int          no_ready = 0;
  logic        done_prev = 1'b0;

  instruction_ram_loader dut (
    .clock                 (clock),
    .reset_n               (reset_n),
    .start                 (start),
    .abort                 (abort),
    .byte_in               (byte_in),
    .byte_valid            (byte_valid),
    .byte_ready            (byte_ready),
    .i_ram_writing_address (i_ram_writing_address),
    .i_ram_input           (i_ram_input),
    .flag_write_i_ram      (flag_write_i_ram),
    .busy                  (busy),
    .done                  (done),
    .error                 (error)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  // Observe RAM port and status mid-cycle.
  always @(negedge clock) begin
    if (flag_write_i_ram === 1'b1) begin
      wr_addr.push_back(i_ram_writing_address);
      wr_data.push_back(i_ram_input);
      wr_cyc.push_back(cyc);
    end
    if (busy === 1'b1 && byte_ready !== 1'b1) no_ready++;
    if (done === 1'b1 && done_prev !== 1'b1) done_cyc = cyc;
    done_prev = done;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap, output int acc);
    byte_valid = 1'b1;
    byte_in    = b;
    tick();
    acc        = cyc;
    byte_valid = 1'b0;
    if (gap) tick();
  endtask

  // Reference: words land at consecutive addresses from 0, each pulse in the
  // cycle after its 4th byte; oversize counts are rejected with no writes.
  task automatic run_load(input int n, input bit gap, input bit corrupt, input string tag);
    int          acc, len_cyc, fin_cyc, nexp;
    int          exp_cyc[$];
    logic [7:0]  x, hi, lo, b;
    logic [31:0] w;
    bit          too_long, exp_done;
    too_long = (n > DEPTH);
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    done_cyc = -1;
    no_ready = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    hi = 8'((n >> 8) & 255);
    lo = 8'(n & 255);
    x  = hi ^ lo;
    send_byte(hi, gap, acc);
    send_byte(lo, gap, len_cyc);
    fin_cyc = len_cyc;
    if (!too_long) begin
      for (int i = 0; i < n; i++) begin
        w = words_q[i];
        for (int k = 0; k < 4; k++) begin
          b = 8'((w >> (24 - 8 * k)) & 32'hFF);
          x ^= b;
          send_byte(b, gap, acc);
        end
        exp_cyc.push_back(acc);
      end
      if (n > 0) fin_cyc = exp_cyc[n-1] + 1;
`ifdef ILOADER_CHECKSUM_EN
      send_byte(corrupt ? ~x : x, gap, fin_cyc);
`endif
    end
    for (int k = 0; k < 20 && !(done === 1'b1 || error === 1'b1); k++) tick();
    repeat (2) tick();
    exp_done = !too_long;
`ifdef ILOADER_CHECKSUM_EN
    if (corrupt) exp_done = 1'b0;
`endif
    nexp = too_long ? 0 : n;
    check({tag, " done"},    32'(done),  32'(exp_done));
    check({tag, " error"},   32'(error), 32'(!exp_done));
    check({tag, " busy"},    32'(busy),  32'h0);
    check({tag, " nwrites"}, wr_addr.size(), nexp);
    check({tag, " ready_in_busy"}, no_ready, 0);
    if (exp_done) check({tag, " done_cycle"}, done_cyc, fin_cyc);
    for (int i = 0; i < nexp && i < wr_addr.size(); i++) begin
      check({tag, $sformatf(" addr[%0d]", i)}, 32'(wr_addr[i]), i);
      check({tag, $sformatf(" data[%0d]", i)}, wr_data[i], words_q[i]);
      check({tag, $sformatf(" pulse_cyc[%0d]", i)}, wr_cyc[i], exp_cyc[i]);
    end
  endtask

  task automatic fill_random(input int n);
    words_q.delete();
    for (int i = 0; i < n; i++) words_q.push_back($urandom());
  endtask

  initial begin
    int acc, n;
    bit gap;

    repeat (3) tick();
    check("rst byte_ready", 32'(byte_ready), 0);
    check("rst flag_write", 32'(flag_write_i_ram), 0);
    check("rst busy",       32'(busy), 0);
    check("rst done",       32'(done), 0);
    check("rst error",      32'(error), 0);
    check("rst addr",       32'(i_ram_writing_address), 0);
    check("rst data",       i_ram_input, 0);
    reset_n = 1'b1;
    repeat (2) tick();

    words_q.delete();
    words_q.push_back(32'hDEADBEEF);
    words_q.push_back(32'h01234567);
    run_load(2, 1'b0, 1'b0, "two_words");

    words_q.delete();
    run_load(0, 1'b0, 1'b0, "zero_len");

    run_load(617, 1'b0, 1'b0, "too_long");

    fill_random(616);
    run_load(616, 1'b0, 1'b0, "full_depth");

    fill_random(3);
    run_load(3, 1'b1, 1'b0, "gapped");

    // Abort coincident with the 4th byte of the second word.
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    start = 1'b1; tick(); start = 1'b0;
    send_byte(8'h00, 1'b0, acc);
    send_byte(8'h02, 1'b0, acc);
    send_byte(8'hCA, 1'b0, acc); send_byte(8'hFE, 1'b0, acc);
    send_byte(8'hF0, 1'b0, acc); send_byte(8'h0D, 1'b0, acc);
    send_byte(8'h12, 1'b0, acc); send_byte(8'h34, 1'b0, acc);
    send_byte(8'h56, 1'b0, acc);
    byte_valid = 1'b1; byte_in = 8'h78; abort = 1'b1;
    tick();
    byte_valid = 1'b0; abort = 1'b0;
    check("abort busy",  32'(busy), 0);
    check("abort ready", 32'(byte_ready), 0);
    check("abort done",  32'(done), 0);
    check("abort error", 32'(error), 0);
    repeat (3) tick();
    check("abort nwrites", wr_addr.size(), 1);
    if (wr_addr.size() > 0) begin
      check("abort addr0", 32'(wr_addr[0]), 0);
      check("abort data0", wr_data[0], 32'hCAFEF00D);
    end

    fill_random(2);
    run_load(2, 1'b0, 1'b0, "after_abort");

    for (int r = 0; r < 4; r++) begin
      n   = $urandom_range(1, 8);
      gap = 1'($urandom_range(0, 1));
      fill_random(n);
      run_load(n, gap, 1'b0, $sformatf("rand%0d", r));
    end

`ifdef ILOADER_CHECKSUM_EN
    words_q.delete();
    words_q.push_back(32'h11223344);
    run_load(1, 1'b0, 1'b0, "csum_good");
    run_load(1, 1'b0, 1'b1, "csum_bad");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_ram_loader.md
Name: instruction_ram_loader

Overview:
Boot-time loader directly upstream of the instruction RAM. Consumes a byte stream (UART receiver or host link) carrying a word count followed by big-endian 32-bit instructions. Drives the RAM write port (i_ram_writing_address, i_ram_input, flag_write_i_ram) at consecutive addresses. Holds busy while loading so the core stays stalled.

Parameters:
DEPTH, 616, number of 32-bit words in the instruction RAM
ADDR_W, 10, RAM address width
BASE_ADDR, 0, first RAM address written

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begins a load when idle
abort  input  1  returns to IDLE from any state, no further writes
byte_in  input  8  stream byte
byte_valid  input  1  byte_in valid this cycle
byte_ready  output  1  loader accepts byte this cycle
i_ram_writing_address  output  ADDR_W  RAM write address
i_ram_input  output  32  RAM write data
flag_write_i_ram  output  1  RAM write enable, one-cycle pulse per word
busy  output  1  high from accepted start until DONE/ERROR/IDLE
done  output  1  level; load completed, held until next start
error  output  1  level; load rejected, held until next start

Behaviour:
- Reset: all outputs 0; state IDLE; address register = BASE_ADDR; byte counter 0.
- Byte handshake: byte accepted on rising edge where byte_valid && byte_ready. byte_ready = 1 only in LEN_HI, LEN_LO, DATA, CHECK; combinational from state.
- States: IDLE, LEN_HI, LEN_LO, DATA, CHECK (only with feature), DONE, ERROR.
- IDLE/DONE/ERROR: start -> LEN_HI, clear done/error, set busy, address = BASE_ADDR. start in any other state ignored.
- LEN_HI: accept byte -> count[15:8], go LEN_LO. LEN_LO: accept byte -> count[7:0], then:
  count == 0 -> DONE (CHECK first if feature enabled); count > DEPTH-BASE_ADDR -> ERROR, no writes; else DATA.
- DATA: bytes shift into assembly register MSB first (first byte -> bits 31:24). On 4th accepted byte, the word is copied to the i_ram_input register and i_ram_writing_address register; flag_write_i_ram = 1 on the following cycle exactly. Write latency: 1 cycle after the 4th byte.
- Address increments by 1 after each write pulse; it never exceeds BASE_ADDR+count-1, so no wrap.
- byte_ready stays high during the write pulse. The next word assembles in parallel; back-to-back bytes every cycle are sustained.
- After the last word's 4th byte: the write pulse issues, then on the next cycle go DONE (or CHECK). done=1, busy=0.
- abort (priority over all events incl. start and byte accept): -> IDLE next cycle; busy=0, flag_write_i_ram=0; a write pulse already registered for the same cycle is suppressed. done/error cleared.
- Partial word at abort is discarded. reset_n low mid-load: same as abort plus all registers to reset values.
- Outputs i_ram_input/i_ram_writing_address hold their last value between pulses.

Optional Feature:
ILOADER_CHECKSUM_EN: defined -> after the last data byte, state CHECK accepts one byte. If it equals the XOR of all length and data bytes -> DONE; mismatch -> ERROR. Words already written stay written. count==0 still goes through CHECK (expected = XOR of both length bytes). Undefined -> no CHECK state; stream ends after the data bytes.

Decomposition:
- Package iloader_pkg: state enum (IDLE..ERROR), ILOADER_LEN_BYTES=2, ILOADER_WORD_BYTES=4, default DEPTH/ADDR_W constants shared with the instruction RAM.
- One sub-module: iloader_word_assembler (byte shift register + 2-bit byte counter, emits word_valid pulse and word). FSM, address counter and checksum stay in top.

Test Plan:
- start; bytes 00 02 DE AD BE EF 01 23 45 67 every cycle -> writes 0xDEADBEEF @0 and 0x01234567 @1, each pulse 1 cycle after the 4th byte; done=1 the cycle after the second pulse.
- count 00 00 -> no flag_write_i_ram; done=1 two cycles after start; busy=0.
- count 0x0269 (617) with DEPTH=616 -> error=1, zero writes; count 0x0268 -> 616 writes, last at address 615.
- byte_valid toggling 1/0 per cycle during 3 words -> identical data/addresses, one pulse per word, byte_ready never drops in DATA.
- abort asserted on same cycle as a word's 4th byte -> no write pulse; IDLE next cycle; later start reloads from BASE_ADDR.
- ILOADER_CHECKSUM_EN: count 00 01, data 11 22 33 44, checksum 0x45 -> done; checksum 0x00 -> error=1, word 0x11223344 still written @0.
